// File: rtl/wb_debug_splitter.sv
// Splits the Wishbone slave window into a user region and a DBG_REGS-word debug bank and force-completes stalled user accesses.
// Optional timeout status register in the last debug slot: define DBG_TIMEOUT_STATUS_EN.
module wb_debug_splitter #(
  parameter int          DBG_REGS  = 2,
  parameter logic [31:0] DBG_BASE  = 32'h300F_FFF8,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] TOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic                    usr_cyc_o,
  input  logic                    usr_ack_i,
  input  logic [31:0]             usr_dat_i,
  output logic [32*DBG_REGS-1:0]  dbg_regs_o,
  output logic                    tout_irq_o
);
  localparam int            AW    = $clog2(DBG_REGS);
  localparam logic [AW-1:0] LAST  = AW'(DBG_REGS - 1);
  localparam logic [15:0]   LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, TOUT} state_t;

  state_t        state;
  logic [15:0]   cnt;
  logic [31:0]   regs [DBG_REGS];
  logic          dbg_ack;
  logic [31:0]   dbg_rdata;
  logic          hit_dbg;
  logic [AW-1:0] idx;
  logic          usr_req;
  logic          dbg_req;
  logic          tout_evt;
  logic          status_sel;
  logic [1:0]    unused_adr;

  assign unused_adr = wbs_adr_i[1:0];
  assign hit_dbg    = (wbs_adr_i[31:AW+2] == DBG_BASE[31:AW+2]);
  assign idx        = wbs_adr_i[AW+1:2];
  assign usr_req    = wbs_cyc_i & wbs_stb_i & ~hit_dbg;
  // Gating on dbg_ack turns a held strobe into one ack every other cycle.
  assign dbg_req    = wbs_cyc_i & wbs_stb_i & hit_dbg & ~dbg_ack;
  // User ack wins over the timeout when both land on the limit cycle.
  assign tout_evt   = (state == WAIT) & usr_req & ~usr_ack_i & (cnt == LIMIT);
  assign usr_cyc_o  = wbs_cyc_i & ~hit_dbg & (state != TOUT);

`ifdef DBG_TIMEOUT_STATUS_EN
  logic        status_clr;
  logic [15:0] st_cnt_nxt;
  assign status_sel = (idx == LAST);
  assign status_clr = dbg_req & wbs_we_i & status_sel;
  assign st_cnt_nxt = status_clr ? 16'd1 :
                      (regs[LAST][15:0] == 16'hFFFF) ? 16'hFFFF : regs[LAST][15:0] + 16'd1;
`else
  assign status_sel = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int k = 0; k < DBG_REGS; k++) regs[k] <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= dbg_req;
      if (dbg_req) begin
        dbg_rdata <= regs[idx];
        if (wbs_we_i && !status_sel) begin
          for (int b = 0; b < 4; b++)
            if (wbs_sel_i[b]) regs[idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
        end
      end
`ifdef DBG_TIMEOUT_STATUS_EN
      if (tout_evt)
        regs[LAST] <= {wbs_adr_i[17:2], st_cnt_nxt};
      else if (status_clr)
        regs[LAST] <= '0;
`endif
    end
  end

  // Leaving WAIT on a dropped strobe/cycle or a debug hit is a silent abort.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state      <= IDLE;
      cnt        <= '0;
      tout_irq_o <= 1'b0;
    end else begin
      tout_irq_o <= 1'b0;
      case (state)
        IDLE: begin
          if (usr_req && !usr_ack_i) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (usr_ack_i || !usr_req) begin
            state <= IDLE;
          end else if (tout_evt) begin
            state      <= TOUT;
            tout_irq_o <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        TOUT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wbs_ack_o = usr_ack_i;
    wbs_dat_o = usr_dat_i;
    if (hit_dbg) begin
      wbs_ack_o = dbg_ack;
      wbs_dat_o = dbg_rdata;
    end else if (state == TOUT) begin
      wbs_ack_o = 1'b1;
      wbs_dat_o = TOUT_DATA;
    end
  end

  for (genvar k = 0; k < DBG_REGS; k++) begin : g_flat
    assign dbg_regs_o[32*k +: 32] = regs[k];
  end
endmodule

// File: tb/tb_wb_debug_splitter.sv
// Randomised directed bench for wb_debug_splitter against a transaction-level model.
module tb_wb_debug_splitter;
  localparam int          NR   = 2;
  localparam int          TO   = 255;
  localparam logic [31:0] BASE = 32'h300F_FFF8;
  localparam logic [31:0] TD   = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cyc = 1'b0, stb = 1'b0, we_s = 1'b0;
  logic [3:0]        sel_s = '0;
  logic [31:0]       wadr = '0, wdat = '0;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              usr_cyc_o;
  logic              usr_ack = 1'b0;
  logic [31:0]       usr_dat = '0;
  logic [32*NR-1:0]  dbg_regs_o;
  logic              tout_irq_o;

  int checks = 0;
  int passes = 0;
  logic [31:0] mreg [NR];
`ifdef DBG_TIMEOUT_STATUS_EN
  int          m_cnt = 0;
  logic [15:0] m_sadr = '0;
`endif

  always #5 clk = ~clk;

  wb_debug_splitter #(.DBG_REGS(NR), .DBG_BASE(BASE), .TIMEOUT(TO), .TOUT_DATA(TD)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we_s), .wbs_sel_i(sel_s),
    .wbs_adr_i(wadr), .wbs_dat_i(wdat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .usr_cyc_o(usr_cyc_o), .usr_ack_i(usr_ack), .usr_dat_i(usr_dat),
    .dbg_regs_o(dbg_regs_o), .tout_irq_o(tout_irq_o)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_read(input int k);
`ifdef DBG_TIMEOUT_STATUS_EN
    if (k == NR-1) return {m_sadr, m_cnt[15:0]};
`endif
    return mreg[k];
  endfunction

  function automatic void m_write(input int k, input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] mask;
`ifdef DBG_TIMEOUT_STATUS_EN
    if (k == NR-1) begin
      m_cnt  = 0;
      m_sadr = '0;
      return;
    end
`endif
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    mreg[k] = (mreg[k] & ~mask) | (d & mask);
  endfunction

  task automatic check_regs(input string tag);
    for (int k = 0; k < NR; k++)
      check($sformatf("%s dbg_regs_o[%0d]", tag, k), dbg_regs_o[32*k +: 32], m_read(k));
  endtask

  // Bus master plus user-slave responder that acks ulat cycles after the strobe (never if ulat < 0).
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, input int ulat, input logic [31:0] udat,
                         output logic [31:0] rd, output int lat, output int irqs, output int ucyc);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; wadr = adr; we_s = we; sel_s = sel; wdat = dat;
    lat = 0; irqs = 0; ucyc = 0; rd = 'x;
    while (1) begin
      usr_ack = (ulat >= 0 && lat == ulat);
      usr_dat = usr_ack ? udat : 32'h0;
      #1;
      if (tout_irq_o) irqs++;
      if (usr_cyc_o) ucyc++;
      if (wbs_ack_o) begin
        rd = wbs_dat_o;
        break;
      end
      if (lat >= 400) begin
        lat = -1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    cyc = 1'b0; stb = 1'b0; we_s = 1'b0; usr_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      if (tout_irq_o) irqs++;
    end
  endtask

  task automatic do_xfer(input string tag, input logic [31:0] adr, input logic we,
                         input logic [3:0] sel, input logic [31:0] dat, input int ulat,
                         input logic [31:0] udat);
    logic [31:0] rd, erd;
    int lat, irqs, ucyc, elat, eirq, k;
    bit hit;
    hit = ((adr & ~32'(NR*4-1)) == BASE);
    k = int'((adr >> 2) % NR);
    if (hit) begin
      elat = 1; eirq = 0; erd = m_read(k);
      if (we) m_write(k, sel, dat);
    end else if (ulat >= 1 && ulat <= TO) begin
      elat = ulat; eirq = 0; erd = udat;
    end else begin
      elat = TO + 1; eirq = 1; erd = TD;
`ifdef DBG_TIMEOUT_STATUS_EN
      m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      m_sadr = adr[17:2];
`endif
    end
    wb_xfer(adr, we, sel, dat, ulat, udat, rd, lat, irqs, ucyc);
    check({tag, " latency"}, lat, elat);
    if (!we) check({tag, " rdata"}, rd, erd);
    check({tag, " irq pulses"}, irqs, eirq);
    if (hit) check({tag, " usr_cyc_o"}, ucyc, 0);
  endtask

  initial begin
    int acks, irqs;
    logic [31:0] a;
    for (int k = 0; k < NR; k++) mreg[k] = '0;

    repeat (3) @(negedge clk);
    #1;
    check("reset ack", wbs_ack_o, 1'b0);
    check("reset irq", tout_irq_o, 1'b0);
    check_regs("reset");
    rst_n = 1'b1;

    do_xfer("rd dbg0", BASE, 1'b0, 4'hF, 32'h0, -1, 32'h0);
    do_xfer("rd dbg1", BASE + 4, 1'b0, 4'hF, 32'h0, -1, 32'h0);
    do_xfer("wr dbg0 sel3", BASE, 1'b1, 4'b0011, 32'hA5A5_1234, -1, 32'h0);
    do_xfer("rd dbg0 back", BASE, 1'b0, 4'hF, 32'h0, -1, 32'h0);
    check_regs("after wr");

    do_xfer("usr rd ack3", 32'h3000_0000, 1'b0, 4'hF, 32'h0, 3, 32'h1111_2222);
    do_xfer("usr rd timeout", 32'h3000_0000, 1'b0, 4'hF, 32'h0, -1, 32'h0);
    do_xfer("rd status slot", BASE + 4*(NR-1), 1'b0, 4'hF, 32'h0, -1, 32'h0);
    do_xfer("usr ack at limit", 32'h3000_0010, 1'b0, 4'hF, 32'h0, TO, 32'h7777_0001);
    do_xfer("usr ack after limit", 32'h3000_0ABC, 1'b0, 4'hF, 32'h0, TO + 1, 32'h7777_0002);
    do_xfer("usr wr timeout", 32'h3000_0020, 1'b1, 4'hF, 32'hFFFF_FFFF, -1, 32'h0);
    check_regs("after usr timeouts");

    // Held strobe on a debug address: one ack every second cycle.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_s = 1'b0; wadr = BASE;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (wbs_ack_o) acks++;
      @(negedge clk);
    end
    cyc = 1'b0; stb = 1'b0;
    check("held stb acks", acks, 3);

    // Cycle dropped during WAIT: no late ack or irq.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; wadr = 32'h3000_0040; usr_ack = 1'b0;
    repeat (5) @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    acks = 0; irqs = 0;
    for (int i = 0; i < TO + 20; i++) begin
      #1;
      if (wbs_ack_o) acks++;
      if (tout_irq_o) irqs++;
      @(negedge clk);
    end
    check("abort acks", acks, 0);
    check("abort irqs", irqs, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = BASE + 32'(4 * $urandom_range(0, NR-1));
        do_xfer($sformatf("rnd dbg %0d", n), a, 1'($urandom), 4'($urandom), $urandom, -1, 32'h0);
      end else begin
        a = $urandom & 32'hFFFF_FFFC;
        if ((a & ~32'(NR*4-1)) == BASE) a = a ^ 32'h0000_1000;
        do_xfer($sformatf("rnd usr %0d", n), a, 1'($urandom), 4'hF, $urandom,
                (n % 17 == 5) ? -1 : $urandom_range(1, 8), $urandom);
      end
    end
    check_regs("after random");

    // Asynchronous reset in the middle of a stalled user access.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_s = 1'b0; wadr = 32'h3000_0100; usr_ack = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < NR; k++) mreg[k] = '0;
`ifdef DBG_TIMEOUT_STATUS_EN
    m_cnt = 0; m_sadr = '0;
`endif
    #1;
    check("async rst ack", wbs_ack_o, 1'b0);
    check("async rst irq", tout_irq_o, 1'b0);
    check_regs("async rst");
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_xfer("post rst usr", 32'h3000_0200, 1'b0, 4'hF, 32'h0, 3, 32'h2468_ACE0);
    do_xfer("post rst timeout", 32'h3000_0204, 1'b0, 4'hF, 32'h0, -1, 32'h0);
    check_regs("final");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
